// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and helpers for the traffic phase scheduler.
//   sched_state_t : scheduler FSM states
//   CNT_W         : width of one per-direction vehicle count
//   TIME_W        : width of red/green durations (seconds)
//   WDOG_W        : width of the phase watchdog counter (seconds)
//   clamp_green() : green duration for a given queue length
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ISSUE  = 2'd2,
        WAIT   = 2'd3
    } sched_state_t;

    localparam int CNT_W  = 5;
    localparam int TIME_W = 5;
    localparam int WDOG_W = 6;

    // Green = min + per-car * count, computed on 8 bits and clamped into
    // [min_green, max_green]. The lower clamp only matters if the 8-bit sum
    // wrapped, which keeps the result sane for unusual parameter mixes.
    function automatic logic [TIME_W-1:0] clamp_green(
        input logic [CNT_W-1:0] cnt,
        input int               min_green,
        input int               max_green,
        input int               sec_per_car
    );
        logic [7:0] g;
        g = 8'(min_green) + 8'(sec_per_car) * {3'b000, cnt};
        if (g < 8'(min_green)) g = 8'(min_green);
        if (g > 8'(max_green)) g = 8'(max_green);
        return g[TIME_W-1:0];
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_rr_dir_picker.sv
// rr_dir_picker: combinational round-robin search.
//   demand_mask : one bit per direction, set when that direction has demand
//   last_dir    : most recently served direction
//   next_dir    : first flagged direction after last_dir (wrapping)
//   found       : high when any direction is flagged; next_dir is 0 otherwise
module rr_dir_picker #(
    parameter int N_DIR = 4,
    parameter int DIR_W = $clog2(N_DIR)
) (
    input  logic [N_DIR-1:0] demand_mask,
    input  logic [DIR_W-1:0] last_dir,
    output logic [DIR_W-1:0] next_dir,
    output logic             found
);

    always_comb begin
        int         cand;
        logic [DIR_W-1:0] cand_idx;
        found    = 1'b0;
        next_dir = '0;
        cand     = 0;
        cand_idx = '0;
        // Distance 1 is checked first, so the closest flagged direction wins.
        for (int k = 1; k <= N_DIR; k++) begin
            cand = int'(last_dir) + k;
            if (cand >= N_DIR) cand = cand - N_DIR;
            cand_idx = DIR_W'(cand);
            if (!found && demand_mask[cand_idx]) begin
                found    = 1'b1;
                next_dir = cand_idx;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: chooses which approach the light FSM serves next
// (emergency first, then round-robin over approaches with demand, else plain
// rotation), sizes its green time from the queued vehicle count, and hands
// the phase over a valid/ready handshake. A seconds watchdog recovers from a
// light FSM that never reports completion.
//   clk, reset      : clock, asynchronous active-high reset
//   tick_sec        : one-cycle pulse per second
//   car_cnt(_valid) : packed 5-bit counts per direction, load strobe
//   emg_req/emg_dir : emergency vehicle present / its approach
//   cfg_ready       : light FSM can take a config
//   phase_done      : light FSM finished green
//   cfg_valid, dir_sel, red_time, green_time : config offer
//   busy            : phase issued or running
//   fault           : sticky, watchdog expired at least once
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int N_DIR       = 4,
    parameter int RED_TIME    = 3,
    parameter int MIN_GREEN   = 5,
    parameter int MAX_GREEN   = 20,
    parameter int SEC_PER_CAR = 2,
    parameter int TIMEOUT_S   = 63
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick_sec,
    input  logic [N_DIR*5-1:0]         car_cnt,
    input  logic                       car_cnt_valid,
    input  logic                       emg_req,
    input  logic [$clog2(N_DIR)-1:0]   emg_dir,
    input  logic                       cfg_ready,
    input  logic                       phase_done,
    output logic                       cfg_valid,
    output logic [$clog2(N_DIR)-1:0]   dir_sel,
    output logic [4:0]                 red_time,
    output logic [4:0]                 green_time,
    output logic                       busy,
    output logic                       fault
);

    localparam int DIR_W = $clog2(N_DIR);

    sched_state_t      state_q, state_d;
    logic              cfg_valid_q, cfg_valid_d;
    logic [DIR_W-1:0]  dir_sel_q, dir_sel_d;
    logic [TIME_W-1:0] red_q, red_d;
    logic [TIME_W-1:0] green_q, green_d;
    logic              busy_q, busy_d;
    logic              fault_q, fault_d;
    logic [DIR_W-1:0]  last_dir_q, last_dir_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic [CNT_W-1:0]  cnt_q [N_DIR];
    logic [CNT_W-1:0]  cnt_d [N_DIR];

    logic [CNT_W-1:0]  car_cnt_arr [N_DIR];
    logic [N_DIR-1:0]  demand_mask;
    logic [DIR_W-1:0]  rr_dir;
    logic              rr_found;
    logic [DIR_W-1:0]  rot_dir;
    logic              emg_ok;
    logic [DIR_W-1:0]  pick_dir;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIR; gi++) begin : g_dir
            assign car_cnt_arr[gi] = car_cnt[5*gi +: 5];
            assign demand_mask[gi] = |cnt_q[gi];
        end
        // When N_DIR fills the index width every encoding is a real approach.
        if ((1 << DIR_W) == N_DIR) begin : g_emg_full
            assign emg_ok = 1'b1;
        end else begin : g_emg_part
            assign emg_ok = (emg_dir < DIR_W'(N_DIR));
        end
    endgenerate

    rr_dir_picker #(
        .N_DIR (N_DIR),
        .DIR_W (DIR_W)
    ) u_picker (
        .demand_mask (demand_mask),
        .last_dir    (last_dir_q),
        .next_dir    (rr_dir),
        .found       (rr_found)
    );

    assign rot_dir  = (int'(last_dir_q) == N_DIR - 1) ? '0 : last_dir_q + DIR_W'(1);
    assign pick_dir = (emg_req && emg_ok) ? emg_dir : (rr_found ? rr_dir : rot_dir);

    always_comb begin
        state_d     = state_q;
        cfg_valid_d = cfg_valid_q;
        dir_sel_d   = dir_sel_q;
        red_d       = red_q;
        green_d     = green_q;
        fault_d     = fault_q;
        last_dir_d  = last_dir_q;
        wdog_d      = wdog_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: state_d = SELECT;
            SELECT: begin
                dir_sel_d   = pick_dir;
                last_dir_d  = pick_dir;
                red_d       = TIME_W'(RED_TIME);
                green_d     = clamp_green(cnt_q[pick_dir], MIN_GREEN, MAX_GREEN, SEC_PER_CAR);
                cfg_valid_d = 1'b1;
                state_d     = ISSUE;
            end
            ISSUE: begin
                if (cfg_valid_q && cfg_ready) begin
                    cfg_valid_d = 1'b0;
                    wdog_d      = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                // Completion takes precedence over a same-cycle tick.
                if (phase_done) begin
                    cnt_d[dir_sel_q] = '0;
                    state_d          = SELECT;
                end else if (tick_sec) begin
                    wdog_d = wdog_q + WDOG_W'(1);
                    if (wdog_q == WDOG_W'(TIMEOUT_S - 1)) begin
                        fault_d = 1'b1;
                        state_d = SELECT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh vision frame overrides the served-direction clear.
        if (car_cnt_valid) begin
            for (int i = 0; i < N_DIR; i++) cnt_d[i] = car_cnt_arr[i];
        end

        busy_d = (state_d == ISSUE) || (state_d == WAIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cfg_valid_q <= 1'b0;
            dir_sel_q   <= '0;
            red_q       <= '0;
            green_q     <= '0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
            last_dir_q  <= DIR_W'(N_DIR - 1);
            wdog_q      <= '0;
            for (int i = 0; i < N_DIR; i++) cnt_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cfg_valid_q <= cfg_valid_d;
            dir_sel_q   <= dir_sel_d;
            red_q       <= red_d;
            green_q     <= green_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
            last_dir_q  <= last_dir_d;
            wdog_q      <= wdog_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cfg_valid  = cfg_valid_q;
    assign dir_sel    = dir_sel_q;
    assign red_time   = red_q;
    assign green_time = green_q;
    assign busy       = busy_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with default parameters.
module tb_traffic_phase_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_sec;
    logic [19:0] car_cnt;
    logic        car_cnt_valid;
    logic        emg_req;
    logic [1:0]  emg_dir;
    logic        cfg_ready;
    logic        phase_done;
    logic        cfg_valid;
    logic [1:0]  dir_sel;
    logic [4:0]  red_time;
    logic [4:0]  green_time;
    logic        busy;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    traffic_phase_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .tick_sec      (tick_sec),
        .car_cnt       (car_cnt),
        .car_cnt_valid (car_cnt_valid),
        .emg_req       (emg_req),
        .emg_dir       (emg_dir),
        .cfg_ready     (cfg_ready),
        .phase_done    (phase_done),
        .cfg_valid     (cfg_valid),
        .dir_sel       (dir_sel),
        .red_time      (red_time),
        .green_time    (green_time),
        .busy          (busy),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for an offer and checks its contents.
    task automatic offer(input string tag, input int d, input int g);
        int n = 0;
        while (cfg_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, cfg_valid, 1);
        chk({tag, "_dir"}, dir_sel, d);
        chk({tag, "_green"}, green_time, g);
        chk({tag, "_red"}, red_time, 3);
        chk({tag, "_busy"}, busy, 1);
        $display("offer %s dir=%0d green=%0d red=%0d", tag, dir_sel, green_time, red_time);
    endtask

    task automatic accept();
        cfg_ready = 1'b1;
        @(negedge clk);
        cfg_ready = 1'b0;
        chk("acc_valid_low", cfg_valid, 0);
        chk("acc_busy", busy, 1);
    endtask

    // phase_done pulse, then latency: SELECT (no offer) then offer.
    task automatic finish();
        phase_done = 1'b1;
        @(negedge clk);
        phase_done = 1'b0;
        chk("done_sel_valid", cfg_valid, 0);
        chk("done_sel_busy", busy, 0);
        @(negedge clk);
        chk("done_next_valid", cfg_valid, 1);
    endtask

    task automatic load(input logic [19:0] v);
        car_cnt       = v;
        car_cnt_valid = 1'b1;
        @(negedge clk);
        car_cnt_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick_sec = 1'b1;
            @(negedge clk);
            tick_sec = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; tick_sec = 0; car_cnt = '0; car_cnt_valid = 0;
        emg_req = 0; emg_dir = '0; cfg_ready = 0; phase_done = 0;
        repeat (3) @(negedge clk);
        chk("rst_valid", cfg_valid, 0);
        chk("rst_dir", dir_sel, 0);
        chk("rst_red", red_time, 0);
        chk("rst_green", green_time, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("edge1_valid", cfg_valid, 0);
        @(negedge clk);
        chk("edge2_valid", cfg_valid, 1);
        chk("edge2_dir", dir_sel, 0);

        // Plain rotation with no demand.
        for (int i = 0; i < 4; i++) begin
            offer("rot", i, 5);
            accept();
            finish();
        end
        offer("rot_wrap", 0, 5);
        accept();
        load(20'd7 << 10);
        finish();

        // Demand on dir 2, then cleared.
        offer("dem2", 2, 19);
        accept();
        finish();
        offer("after_clear", 3, 5);

        // Clamp at MAX_GREEN, then zero demand back to MIN_GREEN.
        load(20'd20 << 5);
        accept();
        finish();
        offer("clamp", 1, 20);
        accept();
        load(20'd0);
        finish();
        offer("zero_dem", 2, 5);
        accept();

        // Emergency during WAIT: no abort, then served and re-selected.
        emg_req = 1'b1;
        emg_dir = 2'd3;
        repeat (5) @(negedge clk);
        chk("emg_no_abort_busy", busy, 1);
        chk("emg_no_abort_valid", cfg_valid, 0);
        finish();
        offer("emg1", 3, 5);
        accept();
        finish();
        offer("emg2", 3, 5);
        emg_req = 1'b0;
        accept();
        finish();
        offer("post_emg", 0, 5);

        // Back-pressure: offer held; stray phase_done ignored in ISSUE.
        phase_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            phase_done = 1'b0;
            chk("hold_valid", cfg_valid, 1);
            chk("hold_dir", dir_sel, 0);
            chk("hold_green", green_time, 5);
        end
        accept();

        // Tick coincident with phase_done and a demand load.
        ticks(62);
        chk("pre_coin_fault", fault, 0);
        chk("pre_coin_busy", busy, 1);
        tick_sec = 1'b1; phase_done = 1'b1; car_cnt = 20'd6; car_cnt_valid = 1'b1;
        @(negedge clk);
        tick_sec = 1'b0; phase_done = 1'b0; car_cnt_valid = 1'b0;
        chk("coin_fault", fault, 0);
        chk("coin_busy", busy, 0);
        offer("load_wins", 0, 17);

        // Watchdog expiry retains demand.
        accept();
        ticks(62);
        chk("wd62_fault", fault, 0);
        chk("wd62_busy", busy, 1);
        tick_sec = 1'b1;
        @(negedge clk);
        tick_sec = 1'b0;
        chk("wd_fault", fault, 1);
        chk("wd_busy", busy, 0);
        chk("wd_valid", cfg_valid, 0);
        offer("wd_retain", 0, 17);

        // Asynchronous reset mid-phase.
        accept();
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", cfg_valid, 0);
        chk("arst_dir", dir_sel, 0);
        chk("arst_red", red_time, 0);
        chk("arst_green", green_time, 0);
        chk("arst_busy", busy, 0);
        chk("arst_fault", fault, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("arst_edge1_valid", cfg_valid, 0);
        offer("arst_restart", 0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
